// File: rtl/mul_if.sv
// Start/done handshake bundle for the iterative signed multiplier.
// O_OVF is present only when MUL_OVF_EN is defined.
interface mul_if #(
  parameter int DATA_MUL = 4
);
  logic                  I_EN;
  logic [DATA_MUL-1:0]   I_A;
  logic [DATA_MUL-1:0]   I_B;
  logic [2*DATA_MUL-1:0] O_RSL;
  logic                  O_FN;
  logic                  O_BUSY;
`ifdef MUL_OVF_EN
  logic                  O_OVF;
`endif

  modport master (
    output I_EN, I_A, I_B,
`ifdef MUL_OVF_EN
    input  O_OVF,
`endif
    input  O_RSL, O_FN, O_BUSY
  );

  modport slave (
    input  I_EN, I_A, I_B,
`ifdef MUL_OVF_EN
    output O_OVF,
`endif
    output O_RSL, O_FN, O_BUSY
  );
endinterface

// File: rtl/mul.sv
// Iterative signed shift-add multiplier: DATA_MUL x DATA_MUL -> 2*DATA_MUL, one partial product per clock.
// Define MUL_OVF_EN to add O_OVF (product does not fit in DATA_MUL-bit signed).
module mul #(
  parameter int DATA_MUL = 4
) (
  input  logic  CLK,
  input  logic  RST_n,
  mul_if.slave  bus
);
  localparam int CNT_SZ = $clog2(DATA_MUL);
  localparam int PW     = 2 * DATA_MUL;
  localparam logic [CNT_SZ-1:0] CNT_LAST = CNT_SZ'(DATA_MUL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [PW-1:0]     mcand_q;
  logic [PW-1:0]     mplier_q;
  logic [PW-1:0]     acc_q;
  logic              sign_q;
  logic [CNT_SZ-1:0] cnt_q;
  logic [PW-1:0]     rsl_q;
  logic              fn_q;
  logic              busy_q;

  logic [PW-1:0]     a_ext_d;
  logic [PW-1:0]     b_ext_d;
  logic [PW-1:0]     a_mag_d;
  logic [PW-1:0]     b_mag_d;
  logic [PW-1:0]     acc_d;
  logic [PW-1:0]     rsl_d;

  // Sign-extend to the product width before negating so -2^(N-1) gives an exact magnitude.
  always_comb begin
    a_ext_d = {{DATA_MUL{bus.I_A[DATA_MUL-1]}}, bus.I_A};
    b_ext_d = {{DATA_MUL{bus.I_B[DATA_MUL-1]}}, bus.I_B};
    a_mag_d = bus.I_A[DATA_MUL-1] ? (~a_ext_d + PW'(1)) : a_ext_d;
    b_mag_d = bus.I_B[DATA_MUL-1] ? (~b_ext_d + PW'(1)) : b_ext_d;
  end

  always_comb begin
    acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    rsl_d = sign_q ? (~acc_q + PW'(1)) : acc_q;
  end

`ifdef MUL_OVF_EN
  logic              ovf_q;
  logic [DATA_MUL:0] top_bits_d;
  logic              ovf_d;

  // Fits in DATA_MUL-bit signed only if the upper bits are a pure sign extension.
  always_comb begin
    top_bits_d = rsl_d[PW-1:DATA_MUL-1];
    ovf_d      = !((&top_bits_d) || (~|top_bits_d));
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == DONE) begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.O_OVF = ovf_q;
`endif

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
      rsl_q    <= '0;
      fn_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      fn_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.I_EN) begin
            mcand_q  <= a_mag_d;
            mplier_q <= b_mag_d;
            sign_q   <= bus.I_A[DATA_MUL-1] ^ bus.I_B[DATA_MUL-1];
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= CALC;
          end
        end
        CALC: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_SZ'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          rsl_q   <= rsl_d;
          fn_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.O_RSL  = rsl_q;
  assign bus.O_FN   = fn_q;
  assign bus.O_BUSY = busy_q;
endmodule

// File: tb/tb_mul.sv
// Self-checking bench for mul at DATA_MUL=4: directed corner cases plus random operands
// against an integer-arithmetic reference model.
module tb_mul;
  localparam int N = 4;

  logic CLK;
  logic RST_n;
  int   total_cnt;
  int   pass_cnt;

  mul_if #(.DATA_MUL(N)) bus ();
  mul #(.DATA_MUL(N)) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  // Reference: plain signed integer product and range test.
  function automatic logic [2*N-1:0] ref_prod(input logic [N-1:0] a, input logic [N-1:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return (2*N)'(p);
  endfunction

  function automatic logic ref_ovf(input logic [N-1:0] a, input logic [N-1:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return (p > (2**(N-1) - 1)) || (p < -(2**(N-1)));
  endfunction

  function automatic logic get_ovf();
`ifdef MUL_OVF_EN
    return bus.O_OVF;
`else
    return 1'b0;
`endif
  endfunction

  // Drives one operation from posedge+1; returns edges from E0 to O_FN (-1 on timeout).
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                       output int lat, output logic [2*N-1:0] rsl,
                       output logic ovf, output logic one_pulse);
    bus.I_A  = a;
    bus.I_B  = b;
    bus.I_EN = 1'b1;
    @(posedge CLK); #1;
    bus.I_EN = 1'b0;
    bus.I_A  = $urandom_range(0, 15);
    bus.I_B  = $urandom_range(0, 15);
    lat = -1;
    rsl = '0;
    ovf = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK); #1;
      if (bus.O_FN) begin
        lat = i;
        rsl = bus.O_RSL;
        ovf = get_ovf();
        break;
      end
    end
    @(posedge CLK); #1;
    one_pulse = !bus.O_FN;
  endtask

  task automatic test_reset();
    RST_n = 1'b0;
    bus.I_EN = 1'b0;
    bus.I_A = '0;
    bus.I_B = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST_n = 1'b1;
    @(posedge CLK); #1;
    total_cnt++;
    if (bus.O_RSL !== 8'h00 || bus.O_FN !== 1'b0 || bus.O_BUSY !== 1'b0)
      $display("FAIL reset: rsl=%h fn=%b busy=%b required rsl=00 fn=0 busy=0", bus.O_RSL, bus.O_FN, bus.O_BUSY);
    else pass_cnt++;
    $display("reset: rsl=%h fn=%b busy=%b", bus.O_RSL, bus.O_FN, bus.O_BUSY);
  endtask

  task automatic test_directed();
    logic [N-1:0]   ta [8];
    logic [N-1:0]   tb_ [8];
    logic [2*N-1:0] want [8];
    logic           wovf [8];
    int lat; logic [2*N-1:0] rsl; logic ovf; logic one;
    ta = '{4'hA, 4'hC, 4'h3, 4'h7, 4'h3, 4'h8, 4'h8, 4'h0};
    tb_ = '{4'h2, 4'hE, 4'h0, 4'hE, 4'h1, 4'h8, 4'h7, 4'h9};
    want = '{8'hF4, 8'h08, 8'h00, 8'hF2, 8'h03, 8'h40, 8'hC8, 8'h00};
    wovf = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 8; k++) begin
      do_op(ta[k], tb_[k], lat, rsl, ovf, one);
      total_cnt++;
      if (lat !== 5 || rsl !== want[k] || !one)
        $display("FAIL directed%0d: a=%h b=%h lat=%0d rsl=%h one_pulse=%b required lat=5 rsl=%h one_pulse=1",
                 k, ta[k], tb_[k], lat, rsl, one, want[k]);
      else pass_cnt++;
`ifdef MUL_OVF_EN
      total_cnt++;
      if (ovf !== wovf[k])
        $display("FAIL directed_ovf%0d: a=%h b=%h ovf=%b required %b", k, ta[k], tb_[k], ovf, wovf[k]);
      else pass_cnt++;
`endif
      $display("directed%0d: a=%h b=%h lat=%0d rsl=%h ovf=%b", k, ta[k], tb_[k], lat, rsl, ovf);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    logic busy_seen;
    lat = -1;
    busy_seen = 1'b1;
    bus.I_A = 4'h5; bus.I_B = 4'h3; bus.I_EN = 1'b1;
    @(posedge CLK); #1;
    bus.I_EN = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      // Re-pulse start with different operands while the first product is still being formed.
      if (i == 2) begin bus.I_A = 4'h1; bus.I_B = 4'h1; bus.I_EN = 1'b1; end
      else bus.I_EN = 1'b0;
      @(posedge CLK); #1;
      if (i < 5 && !bus.O_BUSY) busy_seen = 1'b0;
      if (bus.O_FN) begin lat = i; break; end
    end
    bus.I_EN = 1'b0;
    total_cnt++;
    if (lat !== 5 || bus.O_RSL !== 8'h0F || !busy_seen)
      $display("FAIL busy_ignore: lat=%0d rsl=%h busy_held=%b required lat=5 rsl=0f busy_held=1", lat, bus.O_RSL, busy_seen);
    else pass_cnt++;
    $display("busy_ignore: lat=%0d rsl=%h", lat, bus.O_RSL);
    @(posedge CLK); #1;
    total_cnt++;
    if (bus.O_FN !== 1'b0 || bus.O_BUSY !== 1'b0)
      $display("FAIL busy_after: fn=%b busy=%b required 0 0", bus.O_FN, bus.O_BUSY);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    logic [2*N-1:0] r1, r2;
    lat1 = -1; lat2 = -1; r1 = '0; r2 = '0;
    bus.I_A = 4'h6; bus.I_B = 4'hD; bus.I_EN = 1'b1;
    @(posedge CLK); #1;
    bus.I_EN = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK); #1;
      if (bus.O_FN) begin lat1 = i; r1 = bus.O_RSL; break; end
    end
    bus.I_A = 4'h9; bus.I_B = 4'h2; bus.I_EN = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK); #1;
      bus.I_EN = 1'b0;
      if (bus.O_FN) begin lat2 = i; r2 = bus.O_RSL; break; end
    end
    total_cnt++;
    if (lat1 !== 5 || r1 !== ref_prod(4'h6, 4'hD))
      $display("FAIL b2b_first: lat=%0d rsl=%h required lat=5 rsl=%h", lat1, r1, ref_prod(4'h6, 4'hD));
    else pass_cnt++;
    total_cnt++;
    if (lat2 !== 6 || r2 !== ref_prod(4'h9, 4'h2))
      $display("FAIL b2b_second: gap=%0d rsl=%h required gap=6 rsl=%h", lat2, r2, ref_prod(4'h9, 4'h2));
    else pass_cnt++;
    $display("back_to_back: first lat=%0d rsl=%h, second gap=%0d rsl=%h", lat1, r1, lat2, r2);
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid_op();
    logic fn_seen;
    int lat; logic [2*N-1:0] rsl; logic ovf; logic one;
    fn_seen = 1'b0;
    bus.I_A = 4'h7; bus.I_B = 4'h7; bus.I_EN = 1'b1;
    @(posedge CLK); #1;
    bus.I_EN = 1'b0;
    repeat (2) @(posedge CLK);
    #3;
    RST_n = 1'b0;
    #2;
    total_cnt++;
    if (bus.O_RSL !== 8'h00 || bus.O_BUSY !== 1'b0 || bus.O_FN !== 1'b0 || get_ovf() !== 1'b0)
      $display("FAIL reset_async: rsl=%h busy=%b fn=%b ovf=%b required 00 0 0 0", bus.O_RSL, bus.O_BUSY, bus.O_FN, get_ovf());
    else pass_cnt++;
    @(negedge CLK);
    RST_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      if (bus.O_FN || bus.O_BUSY) fn_seen = 1'b1;
    end
    total_cnt++;
    if (fn_seen || bus.O_RSL !== 8'h00)
      $display("FAIL reset_mid_op: activity=%b rsl=%h required activity=0 rsl=00", fn_seen, bus.O_RSL);
    else pass_cnt++;
    $display("reset_mid_op: activity=%b rsl=%h", fn_seen, bus.O_RSL);
    do_op(4'hB, 4'h5, lat, rsl, ovf, one);
    total_cnt++;
    if (lat !== 5 || rsl !== ref_prod(4'hB, 4'h5) || !one)
      $display("FAIL after_reset_op: lat=%0d rsl=%h required lat=5 rsl=%h", lat, rsl, ref_prod(4'hB, 4'h5));
    else pass_cnt++;
    $display("after_reset_op: lat=%0d rsl=%h", lat, rsl);
  endtask

  task automatic test_random();
    logic [N-1:0] a, b;
    int lat; logic [2*N-1:0] rsl; logic ovf; logic one;
    for (int k = 0; k < 40; k++) begin
      a = N'($urandom_range(0, 15));
      b = N'($urandom_range(0, 15));
      repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
      do_op(a, b, lat, rsl, ovf, one);
      total_cnt++;
      if (lat !== 5 || rsl !== ref_prod(a, b) || !one)
        $display("FAIL random%0d: a=%h b=%h lat=%0d rsl=%h required lat=5 rsl=%h", k, a, b, lat, rsl, ref_prod(a, b));
      else pass_cnt++;
`ifdef MUL_OVF_EN
      total_cnt++;
      if (ovf !== ref_ovf(a, b))
        $display("FAIL random_ovf%0d: a=%h b=%h ovf=%b required %b", k, a, b, ovf, ref_ovf(a, b));
      else pass_cnt++;
`endif
      $display("random%0d: a=%h b=%h rsl=%h ovf=%b ref_ovf=%b", k, a, b, rsl, ovf, ref_ovf(a, b));
    end
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    test_reset();
    test_directed();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/mul.md
Name: mul

Overview:
- Iterative signed shift-add multiplier, DATA_MUL x DATA_MUL -> 2*DATA_MUL product, one partial product per clock.
- Inverse-operation companion to the sequential signed divider (div) in the BMP180 compensation datapath.
- Uses the same I_EN start pulse / O_FN done pulse handshake as the divider.
- Sign handling: operands are converted to magnitudes, multiplied unsigned, and the result is negated when the operand signs differ.

Parameters:
- DATA_MUL, 4, operand width in bits (>=2); product width is 2*DATA_MUL.
- CNT_SZ, $clog2(DATA_MUL), iteration counter width (derived; not overridden).

Ports:
- CLK  input  1  system clock, 50 MHz.
- RST_n  input  1  reset, asynchronous, active-low.
- I_EN  input  1  start pulse; sampled only in IDLE.
- I_A  input  DATA_MUL  multiplicand, signed two's complement.
- I_B  input  DATA_MUL  multiplier, signed two's complement.
- O_RSL  output  2*DATA_MUL  signed product, registered.
- O_FN  output  1  one-cycle pulse: O_RSL updated.
- O_BUSY  output  1  high while an operation is in progress.

Behaviour:
- Reset (RST_n=0, asynchronous, any state): state=IDLE, O_RSL=0, O_FN=0, O_BUSY=0, cnt=0, internal accumulator and operand registers=0. An in-flight operation is discarded and does not resume after reset.
- FSM states are IDLE, CALC and DONE.
- IDLE, I_EN=1 at edge E0:
  - latch |I_A| and |I_B| zero-extended to 2*DATA_MUL bits;
  - latch sign = I_A[MSB]^I_B[MSB];
  - clear the accumulator, set cnt=0, O_BUSY=1, go to CALC.
- CALC, edges E1..E_DATA_MUL:
  - if multiplier LSB=1, acc += shifted multiplicand;
  - shift the multiplicand left 1 and the multiplier right 1; cnt++;
  - at cnt=DATA_MUL-1, go to DONE.
- DONE, edge E_DATA_MUL+1:
  - O_RSL <= sign ? -acc : acc;
  - O_FN <= 1, O_BUSY <= 0, go to IDLE.
- O_FN returns to 0 on the next edge.
- Latency: O_FN is high in the cycle following edge E0+DATA_MUL+1, i.e. 5 clocks for DATA_MUL=4. Latency is constant and has no early exit on zero operands.
- O_RSL holds its value until the next DONE.
- I_EN while O_BUSY=1 is ignored: operands are not re-latched and timing is unaffected.
- Back-to-back: I_EN=1 in the cycle where O_FN=1 is accepted (state is IDLE), giving a throughput of one product per DATA_MUL+2 clocks.
- Most-negative operand: magnitude of -2^(DATA_MUL-1) is formed in DATA_MUL+1 bits and is exact. (-2^(N-1))^2 = 2^(2N-2) fits in the 2N-bit signed result, so no overflow is possible at full width.
- Zero operand: the result is 0 with no negative zero, since -0 = 0.
- I_A and I_B may change freely after E0.

Optional Feature:
- Macro: MUL_OVF_EN.
- Defined:
  - adds output O_OVF (1 bit, reset 0), registered at the DONE edge together with O_RSL;
  - O_OVF=1 iff the product does not fit in DATA_MUL-bit signed, i.e. O_RSL[2*DATA_MUL-1:DATA_MUL-1] is not all-equal;
  - O_OVF holds until the next DONE.
  - Used when the downstream path truncates to DATA_MUL bits.
- Undefined: port O_OVF and its logic are absent. All other behaviour is identical.

Test Plan (all at DATA_MUL=4):
- Reset: RST_n low then high -> O_RSL=8'h00, O_FN=0, O_BUSY=0.
- Basic signed cases (each: pulse I_EN, check O_FN one-cycle pulse after 5 clocks):
  - I_A=-6, I_B=2 -> O_RSL=8'hF4 (-12);
  - I_A=-4, I_B=-2 -> O_RSL=8'h08;
  - I_A=3, I_B=0 -> O_RSL=8'h00.
- Overflow: I_A=7, I_B=-2 -> O_RSL=8'hF2 (-14), O_OVF=1 with MUL_OVF_EN. Then I_A=3, I_B=1 -> 8'h03, O_OVF=0.
- Extreme operand: I_A=-8, I_B=-8 -> O_RSL=8'h40. I_A=-8, I_B=7 -> 8'hC8 (-56).
- Busy and back-to-back:
  - I_EN re-pulsed mid-CALC with I_A=1, I_B=1 -> ignored, first result delivered on time.
  - I_EN asserted in the O_FN cycle -> second result delivered 6 clocks after the first.
- Reset mid-operation: RST_n pulsed low 2 clocks after I_EN -> no O_FN, O_RSL=0, O_BUSY=0. A following operation completes correctly.
